// File: rtl/mdu_if.sv
// mdu_if: decoder/CP0-facing bundle for the multiply/divide unit.
//   Start  - decoder start strobe, qualifies MDUOp
//   MDUOp  - 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo
//   A, B   - rs / rt operands
//   Req    - CP0 exception/interrupt request for the instruction in this stage
//   Busy   - multi-cycle operation in flight (registered)
//   HI, LO - architectural registers (registered)
//   MDUOut - mfhi/mflo read data (combinational)
// The master modport is the pipeline side; the slave modport is the MDU.
interface mdu_if;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Req;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUOut;

  modport master (
    output Start, MDUOp, A, B, Req,
    input  Busy, HI, LO, MDUOut
  );

  modport slave (
    input  Start, MDUOp, A, B, Req,
    output Busy, HI, LO, MDUOut
  );
endinterface

// File: rtl/mdu.sv
// mdu: MIPS-style multiply/divide unit with HI/LO registers.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset, clears all state
//   bus   - mdu_if.slave (Start, MDUOp, A, B, Req in; Busy, HI, LO, MDUOut out)
// The result is computed at acceptance and held in pending registers; a
// down-counter models the multi-cycle latency (5 for mult, 10 for div) and
// the pending value is committed to HI/LO on the edge the counter hits zero.
// Optional feature: define MDU_REQ_BLOCK_EN to make Req=1 suppress acceptance
// of a new operation; without it Req is ignored.
module mdu (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam int unsigned W       = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned MUL_CYC = 5;
  localparam int unsigned DIV_CYC = 10;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;
  logic [W-1:0]     pend_hi_q, pend_hi_d;
  logic [W-1:0]     pend_lo_q, pend_lo_d;
  logic             pend_ok_q, pend_ok_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic             op_valid;
  logic             accept;
  logic [2*W-1:0]   sx_a, sx_b, zx_a, zx_b;
  logic [2*W-1:0]   prod_s, prod_u;
  logic [W-1:0]     div_bs, div_bu;
  logic [W-1:0]     quo_s, rem_s, quo_u, rem_u;

  // Acceptance qualification
  always_comb begin
    op_valid = bus.Start && !busy_q &&
               (bus.MDUOp >= OP_MULT) && (bus.MDUOp <= OP_MTLO);
`ifdef MDU_REQ_BLOCK_EN
    accept = op_valid && !bus.Req;
`else
    accept = op_valid;
`endif
  end

  // Arithmetic datapath
  always_comb begin
    sx_a   = {{W{bus.A[W-1]}}, bus.A};
    sx_b   = {{W{bus.B[W-1]}}, bus.B};
    zx_a   = {{W{1'b0}}, bus.A};
    zx_b   = {{W{1'b0}}, bus.B};
    // Low 64 bits of a product of sign-extended operands is the signed product
    prod_s = sx_a * sx_b;
    prod_u = zx_a * zx_b;
    // Divide by zero and the INT_MIN/-1 overflow are steered onto a divisor
    // of 1: the former result is discarded, the latter yields A, remainder 0
    div_bs = ((bus.B == '0) ||
              (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF)) ? W'(1) : bus.B;
    div_bu = (bus.B == '0) ? W'(1) : bus.B;
    quo_s  = W'($signed(bus.A) / $signed(div_bs));
    rem_s  = W'($signed(bus.A) % $signed(div_bs));
    quo_u  = bus.A / div_bu;
    rem_u  = bus.A % div_bu;
  end

  // Next-state logic
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_ok_d = pend_ok_q;
    cnt_d     = cnt_q;

    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && pend_ok_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (accept) begin
      unique case (bus.MDUOp)
        OP_MULT: begin
          {pend_hi_d, pend_lo_d} = prod_s;
          pend_ok_d = 1'b1;
          cnt_d     = CNT_W'(MUL_CYC);
        end
        OP_MULTU: begin
          {pend_hi_d, pend_lo_d} = prod_u;
          pend_ok_d = 1'b1;
          cnt_d     = CNT_W'(MUL_CYC);
        end
        OP_DIV: begin
          pend_hi_d = rem_s;
          pend_lo_d = quo_s;
          pend_ok_d = (bus.B != '0);
          cnt_d     = CNT_W'(DIV_CYC);
        end
        OP_DIVU: begin
          pend_hi_d = rem_u;
          pend_lo_d = quo_u;
          pend_ok_d = (bus.B != '0);
          cnt_d     = CNT_W'(DIV_CYC);
        end
        OP_MTHI: hi_d = bus.A;
        OP_MTLO: lo_d = bus.A;
        default: ;
      endcase
    end

    busy_d = (cnt_d != '0);
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_ok_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_ok_q <= pend_ok_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  // Read port is combinational on MDUOp and does not depend on Busy
  always_comb begin
    bus.MDUOut = '0;
    if (bus.MDUOp == OP_MFHI)      bus.MDUOut = hi_q;
    else if (bus.MDUOp == OP_MFLO) bus.MDUOut = lo_q;
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed plus randomized checks of mdu against a transaction-level
// reference (arithmetic on int/longint, a latency countdown, HI/LO values).
module tb_mdu;

  logic clk;
  logic reset;
  mdu_if bus ();

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_ok;
  int          m_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_ok = 0; m_left = 0;
  endtask

  // Result of one operation in architectural terms
  task automatic model_step(input bit st, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b, input bit rq);
    int sa, sb, q, r;
    longint p;
    longint unsigned pu;
    bit blocked;
`ifdef MDU_REQ_BLOCK_EN
    blocked = rq;
`else
    blocked = 0;
`endif
    sa = a; sb = b;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_ok) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (st && op >= 1 && op <= 8 && !blocked) begin
      case (op)
        4'd1: begin
          p = longint'(sa) * longint'(sb);
          {m_phi, m_plo} = 64'(p); m_ok = 1; m_left = 5;
        end
        4'd2: begin
          pu = longint'({32'd0, a}) * longint'({32'd0, b});
          {m_phi, m_plo} = 64'(pu); m_ok = 1; m_left = 5;
        end
        4'd3: begin
          m_left = 10;
          m_ok   = (b != 0);
          if (b == 0) ;
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_plo = a; m_phi = '0;
          end else begin
            q = sa / sb; r = sa % sb;
            m_plo = q; m_phi = r;
          end
        end
        4'd4: begin
          m_left = 10;
          m_ok   = (b != 0);
          if (b != 0) begin m_plo = a / b; m_phi = a % b; end
        end
        4'd7: m_hi = a;
        4'd8: m_lo = a;
        default: ;
      endcase
    end
  endtask

  function automatic logic [31:0] exp_out(input logic [3:0] op);
    if (op == 4'd5) return m_hi;
    if (op == 4'd6) return m_lo;
    return '0;
  endfunction

  // One clock: drive, check read port, clock, check registered state
  task automatic cyc(input bit st, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b, input bit rq);
    bus.Start = st; bus.MDUOp = op; bus.A = a; bus.B = b; bus.Req = rq;
    #1;
    chk("mduout", bus.MDUOut, exp_out(op));
    @(posedge clk);
    model_step(st, op, a, b, rq);
    #1;
    chk("busy", 32'(bus.Busy), 32'(m_left > 0));
    chk("hi", bus.HI, m_hi);
    chk("lo", bus.LO, m_lo);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 4'd0, '0, '0, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.Start = 0; bus.MDUOp = '0; bus.A = '0; bus.B = '0; bus.Req = 0;
    reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    reset = 1'b0;

    // mult / multu of 0xFFFFFFFE * 3
    cyc(1, 4'd1, 32'hFFFF_FFFE, 32'd3, 0);
    idle(5);
    chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
    chk("mult_lo", bus.LO, 32'hFFFF_FFFA);
    cyc(1, 4'd2, 32'hFFFF_FFFE, 32'd3, 0);
    idle(5);
    chk("multu_hi", bus.HI, 32'h0000_0002);
    chk("multu_lo", bus.LO, 32'hFFFF_FFFA);

    // div -7/2, then divu by zero leaves HI/LO alone
    cyc(1, 4'd3, 32'hFFFF_FFF9, 32'd2, 0);
    idle(10);
    chk("div_hi", bus.HI, 32'hFFFF_FFFF);
    chk("div_lo", bus.LO, 32'hFFFF_FFFD);
    cyc(1, 4'd4, 32'd7, 32'd0, 0);
    idle(10);
    chk("divu0_hi", bus.HI, 32'hFFFF_FFFF);
    chk("divu0_lo", bus.LO, 32'hFFFF_FFFD);

    // INT_MIN / -1
    cyc(1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle(10);
    chk("ovf_hi", bus.HI, 32'h0000_0000);
    chk("ovf_lo", bus.LO, 32'h8000_0000);

    // mthi then mfhi; mtlo during Busy is dropped
    cyc(1, 4'd7, 32'h1234_5678, 32'd0, 0);
    chk("mthi_hi", bus.HI, 32'h1234_5678);
    chk("mthi_busy", 32'(bus.Busy), 32'd0);
    cyc(1, 4'd5, '0, '0, 0);
    cyc(1, 4'd1, 32'd2, 32'd3, 0);
    cyc(1, 4'd8, 32'hDEAD_BEEF, 32'd0, 0);
    idle(4);
    chk("mtlo_busy_lo", bus.LO, 32'd6);

    // Reset in the middle of a div
    cyc(1, 4'd3, 32'd100, 32'd7, 0);
    idle(2);
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_busy", 32'(bus.Busy), 32'd0);
    chk("midrst_hi", bus.HI, 32'd0);
    chk("midrst_lo", bus.LO, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(10);
    chk("norecommit_lo", bus.LO, 32'd0);

    // Start with Req asserted
    cyc(1, 4'd1, 32'd9, 32'd9, 1);
`ifdef MDU_REQ_BLOCK_EN
    chk("req_busy", 32'(bus.Busy), 32'd0);
    idle(5);
    chk("req_lo", bus.LO, 32'd0);
`else
    chk("req_busy", 32'(bus.Busy), 32'd1);
    idle(5);
    chk("req_lo", bus.LO, 32'd81);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                       : 4'($urandom_range(1, 8));
      cyc($urandom_range(0, 2) != 0, op, pick(), pick(), $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have ports: clk input 1 (system clock, all state updates on rising edge).
REQ-002 SHALL have: reset input 1 (asynchronous, active-high; clears all state immediately).
REQ-003 SHALL have: Start input 1 (decoder Start; qualifies MDUOp this cycle).
REQ-004 SHALL have: MDUOp input 4 (1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 0 none).
REQ-005 SHALL have: A input 32 (rs operand); B input 32 (rt operand).
REQ-006 SHALL have: Req input 1 (exception/interrupt request from CP0 for the instruction in this stage).
REQ-007 SHALL have: Busy output 1 (multi-cycle operation in flight).
REQ-008 SHALL have: HI output 32, LO output 32 (architectural registers, registered).
REQ-009 SHALL have: MDUOut output 32 (mfhi/mflo read data).
REQ-010 SHALL have one clock domain, clk; reset asynchronous active-high.

Function
REQ-011 SHALL accept an operation when Start=1, Busy=0 and MDUOp in 1..8; otherwise ignore Start.
REQ-012 SHALL, on accepting ops 1-4, compute the result into pending registers, load a counter with 5 (mult/multu) or 10 (div/divu), and assert Busy from the next cycle.
REQ-013 SHALL decrement the counter each edge while nonzero; Busy = (counter != 0), registered.
REQ-014 SHALL commit pending HI/LO on the edge where the counter goes 1->0; with Start accepted at edge E, mult result visible on HI/LO after edge E+5, div after E+10.
REQ-015 SHALL for mult: {HI,LO} = signed 64-bit A*B; multu: unsigned 64-bit A*B.
REQ-016 SHALL for div: LO = A/B signed, truncated toward zero; HI = remainder with dividend's sign; divu: unsigned quotient/remainder.
REQ-017 SHALL for div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-018 SHALL for B=0 (div/divu): still go busy for 10 cycles, then leave HI/LO unchanged.
REQ-019 SHALL for mthi/mtlo accepted: write A to HI/LO at that edge, no Busy.
REQ-020 SHALL drive MDUOut = HI when MDUOp=5, LO when MDUOp=6, else 0, combinationally, regardless of Busy.
REQ-021 SHALL ignore every Start (including mthi/mtlo) while Busy=1; hazard unit stalls on Start|Busy.
REQ-022 SHALL treat Start with MDUOp 0, 5, 6 or 9-15 as no state change.
REQ-023 SHALL keep HI/LO stable except on commit (REQ-014) or mthi/mtlo write (REQ-019).

Reset
REQ-024 SHALL on reset=1 force HI=0, LO=0, pending=0, counter=0, Busy=0 asynchronously, including mid-operation (in-flight result discarded).
REQ-025 SHALL accept a new Start on the first rising edge after reset deasserts.

Configuration
REQ-026 SHALL compile Req blocking under macro MDU_REQ_BLOCK_EN.
REQ-027 SHALL, with MDU_REQ_BLOCK_EN defined, suppress acceptance when Req=1 (no Busy, no mthi/mtlo write); an already in-flight op completes normally.
REQ-028 SHALL, without MDU_REQ_BLOCK_EN, keep the Req port but ignore it.

Verification
REQ-029 SHALL cover: mult A=0xFFFFFFFE, B=3 -> Busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-030 SHALL cover: div A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> Busy 10, HI/LO unchanged.
REQ-031 SHALL cover: mthi A=0x12345678 then mfhi -> HI and MDUOut=0x12345678 next cycle, Busy never set; mtlo during Busy -> LO unchanged.
REQ-032 SHALL cover: reset asserted at cycle 3 of a div -> Busy=0, HI=LO=0 immediately; no commit afterwards.
REQ-033 SHALL cover: with MDU_REQ_BLOCK_EN, Start mult + Req=1 -> Busy stays 0, HI/LO unchanged; without macro -> normal 5-cycle mult.
REQ-034 SHALL cover: div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 after 10 cycles.
